vga_receiver: RTL and testbench

VGA_RECEIVER -- requirements
Module: vga_receiver

---
 rtl/vga_timing_pkg.sv | 28 ++
 rtl/vga_receiver_if.sv | 13 +
 rtl/vga_sync_edge.sv | 26 ++
 rtl/vga_receiver.sv | 193 +++++++++++++++++++
 tb/tb_vga_receiver.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared 640x480 VGA timing constants, lock states and counter helper
package vga_timing_pkg;

    localparam int VGA_H_DATA = 640;
    localparam int VGA_H_FP   = 16;
    localparam int VGA_H_PW   = 96;
    localparam int VGA_H_BP   = 48;
    localparam int VGA_V_DATA = 480;
    localparam int VGA_V_FP   = 10;
    localparam int VGA_V_PW   = 2;
    localparam int VGA_V_BP   = 33;
    localparam int VGA_H_TOTAL = VGA_H_DATA + VGA_H_FP + VGA_H_PW + VGA_H_BP;
    localparam int VGA_V_TOTAL = VGA_V_DATA + VGA_V_FP + VGA_V_PW + VGA_V_BP;
    localparam bit VGA_POLARITY = 1'b1;

    localparam logic [11:0] CNT_MAX = 12'hFFF;

    typedef enum logic [1:0] {
        LOCK_SEARCH = 2'd0,
        LOCK_CHECK  = 2'd1,
        LOCK_LOCKED = 2'd2
    } lock_state_t;

    function automatic logic [11:0] sat_inc(input logic [11:0] v);
        return (v == CNT_MAX) ? v : v + 12'd1;
    endfunction

endpackage

// File: rtl/vga_receiver_if.sv
// rtl/vga_receiver_if.sv - VGA source bundle: sync lines and 10-bit colour channels
interface vga_receiver_if;

    logic       hsync;
    logic       vsync;
    logic [9:0] red;
    logic [9:0] grn;
    logic [9:0] blu;

    modport master (output hsync, vsync, red, grn, blu);
    modport slave  (input  hsync, vsync, red, grn, blu);

endinterface

// File: rtl/vga_sync_edge.sv
// rtl/vga_sync_edge.sv - registers one sync line and flags its idle-to-active transition
module vga_sync_edge #(
    parameter bit POLARITY = 1'b1
) (
    input  logic px_clk,
    input  logic rst,
    input  logic i_sync,
    output logic o_lead
);

    logic r_sync;
    logic r_sync_d;

    always_ff @(posedge px_clk or posedge rst) begin
        if (rst) begin
            r_sync   <= POLARITY;
            r_sync_d <= POLARITY;
        end else begin
            r_sync   <= i_sync;
            r_sync_d <= r_sync;
        end
    end

    assign o_lead = (r_sync_d == POLARITY) && (r_sync != POLARITY);

endmodule

// File: rtl/vga_receiver.sv
// rtl/vga_receiver.sv - VGA receiver: line/frame measurement, lock FSM and active-pixel output
module vga_receiver
    import vga_timing_pkg::*;
#(
    parameter int H_DATA   = VGA_H_DATA,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_PW     = VGA_H_PW,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_DATA   = VGA_V_DATA,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_PW     = VGA_V_PW,
    parameter int V_BP     = VGA_V_BP,
    parameter bit POLARITY = VGA_POLARITY
) (
    input  logic          px_clk,
    input  logic          rst,
    vga_receiver_if.slave i_vga,
    output logic [29:0]   o_px_data,
    output logic [10:0]   o_px_h,
    output logic [10:0]   o_px_v,
    output logic          o_px_valid,
    output logic          o_frame_start,
    output logic          o_locked,
    output logic [11:0]   o_h_total_meas,
    output logic [11:0]   o_v_total_meas,
    output logic          o_timing_err
);

    localparam logic [11:0] L_H_TOTAL = 12'(H_DATA + H_FP + H_PW + H_BP);
    localparam logic [11:0] L_V_TOTAL = 12'(V_DATA + V_FP + V_PW + V_BP);
    localparam logic [11:0] L_H_START = 12'(H_PW + H_BP);
    localparam logic [11:0] L_H_END   = 12'(H_PW + H_BP + H_DATA - 1);
    localparam logic [11:0] L_V_START = 12'(V_PW + V_BP);
    localparam logic [11:0] L_V_END   = 12'(V_PW + V_BP + V_DATA - 1);

    logic [29:0] r_rgb;
    logic [11:0] r_hcnt;
    logic [11:0] r_vline;
    logic [11:0] r_h_total;
    logic [11:0] r_v_total;
    logic [1:0]  r_good_cnt;
    logic        r_frame_bad;
    lock_state_t r_state;

    logic [29:0] r_px_data;
    logic [10:0] r_px_h;
    logic [10:0] r_px_v;
    logic        r_px_valid;
    logic        r_frame_start;
    logic        r_timing_err;

    logic        w_h_lead;
    logic        w_v_lead;
    logic [11:0] w_h_meas;
    logic [11:0] w_v_meas;
    logic [11:0] w_hcnt_cur;
    logic [11:0] w_vline_cur;
    logic        w_line_bad;
    logic        w_v_bad;
    logic        w_in_win;
    logic        w_is_locked;
    lock_state_t w_state_nx;
    logic [1:0]  w_good_nx;
    logic        w_err;

    vga_sync_edge #(.POLARITY(POLARITY)) u_hsync_edge (
        .px_clk (px_clk),
        .rst    (rst),
        .i_sync (i_vga.hsync),
        .o_lead (w_h_lead)
    );

    vga_sync_edge #(.POLARITY(POLARITY)) u_vsync_edge (
        .px_clk (px_clk),
        .rst    (rst),
        .i_sync (i_vga.vsync),
        .o_lead (w_v_lead)
    );

    // *_cur is the position of the pixel now sitting in r_rgb; the counter
    // registers lag it by one sample, hence the +1 in the period measurements.
    assign w_h_meas    = sat_inc(r_hcnt);
    assign w_v_meas    = w_h_lead ? sat_inc(r_vline) : r_vline;
    assign w_hcnt_cur  = w_h_lead ? 12'd0 : w_h_meas;
    assign w_vline_cur = w_v_lead ? 12'd0 : w_v_meas;

    assign w_line_bad  = (w_h_lead && (w_h_meas != L_H_TOTAL)) || (w_hcnt_cur == CNT_MAX);
    assign w_v_bad     = w_v_lead && (w_v_meas != L_V_TOTAL);
    assign w_is_locked = (r_state == LOCK_LOCKED);
    assign w_in_win    = (w_hcnt_cur >= L_H_START) && (w_hcnt_cur <= L_H_END) &&
                         (w_vline_cur >= L_V_START) && (w_vline_cur <= L_V_END);

    always_comb begin
        w_state_nx = r_state;
        w_good_nx  = r_good_cnt;
        w_err      = 1'b0;
        case (r_state)
            LOCK_SEARCH: begin
                if (w_v_lead) begin
                    w_state_nx = LOCK_CHECK;
                    w_good_nx  = 2'd0;
                end
            end
            LOCK_CHECK: begin
                if (w_v_lead) begin
                    if (!r_frame_bad && !w_line_bad && !w_v_bad) begin
                        w_good_nx = r_good_cnt + 2'd1;
                        if (r_good_cnt == 2'd1) begin
                            w_state_nx = LOCK_LOCKED;
                        end
                    end else begin
                        w_good_nx = 2'd0;
                    end
                end
            end
            LOCK_LOCKED: begin
                if (w_line_bad || w_v_bad) begin
                    w_err      = 1'b1;
                    w_state_nx = LOCK_CHECK;
                    w_good_nx  = 2'd0;
                end
            end
            default: begin
                w_state_nx = LOCK_SEARCH;
                w_good_nx  = 2'd0;
            end
        endcase
    end

    always_ff @(posedge px_clk or posedge rst) begin
        if (rst) begin
            r_state    <= LOCK_SEARCH;
            r_good_cnt <= 2'd0;
        end else begin
            r_state    <= w_state_nx;
            r_good_cnt <= w_good_nx;
        end
    end

    // A frame stays marked bad from its first bad line until the next VSYNC
    // edge, so an unlock mid-frame never lets that partial frame count as good.
    always_ff @(posedge px_clk or posedge rst) begin
        if (rst) begin
            r_rgb       <= '0;
            r_hcnt      <= CNT_MAX;
            r_vline     <= CNT_MAX;
            r_h_total   <= '0;
            r_v_total   <= '0;
            r_frame_bad <= 1'b0;
        end else begin
            r_rgb       <= {i_vga.red, i_vga.grn, i_vga.blu};
            r_hcnt      <= w_hcnt_cur;
            r_vline     <= w_vline_cur;
            r_frame_bad <= w_v_lead ? 1'b0 : (r_frame_bad | w_line_bad);
            if (w_h_lead) begin
                r_h_total <= w_h_meas;
            end
            if (w_v_lead) begin
                r_v_total <= w_v_meas;
            end
        end
    end

    always_ff @(posedge px_clk or posedge rst) begin
        if (rst) begin
            r_px_data     <= '0;
            r_px_h        <= '0;
            r_px_v        <= '0;
            r_px_valid    <= 1'b0;
            r_frame_start <= 1'b0;
            r_timing_err  <= 1'b0;
        end else begin
            r_px_data     <= r_rgb;
            r_px_h        <= w_in_win ? 11'(w_hcnt_cur - L_H_START) : 11'd0;
            r_px_v        <= w_in_win ? 11'(w_vline_cur - L_V_START) : 11'd0;
            r_px_valid    <= w_in_win && w_is_locked;
            r_frame_start <= w_in_win && w_is_locked &&
                             (w_hcnt_cur == L_H_START) && (w_vline_cur == L_V_START);
            r_timing_err  <= w_err;
        end
    end

    assign o_px_data      = r_px_data;
    assign o_px_h         = r_px_h;
    assign o_px_v         = r_px_v;
    assign o_px_valid     = r_px_valid;
    assign o_frame_start  = r_frame_start;
    assign o_locked       = w_is_locked;
    assign o_h_total_meas = r_h_total;
    assign o_v_total_meas = r_v_total;
    assign o_timing_err   = r_timing_err;

endmodule

// File: tb/tb_vga_receiver.sv
// tb/tb_vga_receiver.sv - randomized loopback bench for vga_receiver against a pin-level reference model
module tb_vga_receiver;
    import vga_timing_pkg::*;

    localparam int T_H_DATA = 8;
    localparam int T_H_FP   = 2;
    localparam int T_H_PW   = 3;
    localparam int T_H_BP   = 3;
    localparam int T_V_DATA = 4;
    localparam int T_V_FP   = 1;
    localparam int T_V_PW   = 1;
    localparam int T_V_BP   = 2;
    localparam int T_HT     = T_H_DATA + T_H_FP + T_H_PW + T_H_BP;
    localparam int T_VT     = T_V_DATA + T_V_FP + T_V_PW + T_V_BP;
    localparam bit T_POL    = VGA_POLARITY;
    localparam int HS0      = T_H_PW + T_H_BP;
    localparam int VS0      = T_V_PW + T_V_BP;

    logic        px_clk = 1'b0;
    logic        rst    = 1'b1;
    logic [29:0] px_data;
    logic [10:0] px_h, px_v;
    logic        px_valid, frame_start, locked, timing_err;
    logic [11:0] h_total_meas, v_total_meas;

    vga_receiver_if vga_bus();

    vga_receiver #(
        .H_DATA(T_H_DATA), .H_FP(T_H_FP), .H_PW(T_H_PW), .H_BP(T_H_BP),
        .V_DATA(T_V_DATA), .V_FP(T_V_FP), .V_PW(T_V_PW), .V_BP(T_V_BP),
        .POLARITY(T_POL)
    ) dut (
        .px_clk         (px_clk),
        .rst            (rst),
        .i_vga          (vga_bus),
        .o_px_data      (px_data),
        .o_px_h         (px_h),
        .o_px_v         (px_v),
        .o_px_valid     (px_valid),
        .o_frame_start  (frame_start),
        .o_locked       (locked),
        .o_h_total_meas (h_total_meas),
        .o_v_total_meas (v_total_meas),
        .o_timing_err   (timing_err)
    );

    always #5 px_clk = ~px_clk;

    typedef struct {
        logic [29:0] data;
        int          ph;
        int          pv;
        bit          valid;
        bit          fs;
        bit          lck;
        bit          err;
        int          hm;
        int          vm;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_valid  = 0;
    int   n_fs     = 0;
    int   n_err    = 0;

    // Reference model: line length = samples since the last HSYNC leading edge,
    // frame length = HSYNC edges since the last VSYNC leading edge.
    int m_state;
    int m_good;
    bit m_fbad;
    int m_hlen;
    int m_vlines;
    int m_hm;
    int m_vm;
    bit m_prev_hs;
    bit m_prev_vs;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic void model_reset();
        m_state   = 0;
        m_good    = 0;
        m_fbad    = 1'b0;
        m_hlen    = 4096;
        m_vlines  = 4095;
        m_hm      = 0;
        m_vm      = 0;
        m_prev_hs = T_POL;
        m_prev_vs = T_POL;
    endfunction

    function automatic exp_t model_step(input bit hs, input bit vs, input logic [29:0] rgb);
        exp_t e;
        bit   hl, vl, line_bad, was_locked, in_win;
        int   pos;
        hl = (m_prev_hs == T_POL) && (hs != T_POL);
        vl = (m_prev_vs == T_POL) && (vs != T_POL);
        m_prev_hs  = hs;
        m_prev_vs  = vs;
        was_locked = (m_state == 2);
        line_bad   = 1'b0;
        e.err      = 1'b0;
        if (hl) begin
            m_hm     = (m_hlen > 4095) ? 4095 : m_hlen;
            line_bad = (m_hm != T_HT);
            m_hlen   = 1;
            if (m_vlines < 4095) m_vlines++;
        end else if (m_hlen < 4096) begin
            m_hlen++;
        end
        pos = m_hlen - 1;
        if (pos == 4095) line_bad = 1'b1;
        if (vl) begin
            m_vm     = m_vlines;
            m_vlines = 0;
        end
        if (m_state == 2) begin
            if (line_bad || (vl && m_vm != T_VT)) begin
                e.err   = 1'b1;
                m_state = 1;
                m_good  = 0;
            end
        end else if (vl) begin
            if (m_state == 0) begin
                m_state = 1;
                m_good  = 0;
            end else begin
                m_good = (!m_fbad && !line_bad && m_vm == T_VT) ? m_good + 1 : 0;
                if (m_good == 2) m_state = 2;
            end
        end
        m_fbad  = vl ? 1'b0 : (m_fbad | line_bad);
        in_win  = (pos >= HS0) && (pos < HS0 + T_H_DATA) &&
                  (m_vlines >= VS0) && (m_vlines < VS0 + T_V_DATA);
        e.ph    = in_win ? pos - HS0 : 0;
        e.pv    = in_win ? m_vlines - VS0 : 0;
        e.valid = in_win && was_locked;
        e.fs    = e.valid && (e.ph == 0) && (e.pv == 0);
        e.data  = rgb;
        e.lck   = (m_state == 2);
        e.hm    = m_hm;
        e.vm    = m_vm;
        return e;
    endfunction

    task automatic drive(input bit hs, input bit vs, input logic [29:0] rgb);
        vga_bus.hsync = hs;
        vga_bus.vsync = vs;
        vga_bus.red   = rgb[29:20];
        vga_bus.grn   = rgb[19:10];
        vga_bus.blu   = rgb[9:0];
    endtask

    task automatic check_outputs(input exp_t e);
        check_eq("px_valid",     32'(px_valid),     32'(e.valid));
        check_eq("frame_start",  32'(frame_start),  32'(e.fs));
        check_eq("px_h",         32'(px_h),         32'(e.ph));
        check_eq("px_v",         32'(px_v),         32'(e.pv));
        check_eq("px_data",      32'(px_data),      32'(e.data));
        check_eq("locked",       32'(locked),       32'(e.lck));
        check_eq("timing_err",   32'(timing_err),   32'(e.err));
        check_eq("h_total_meas", 32'(h_total_meas), 32'(e.hm));
        check_eq("v_total_meas", 32'(v_total_meas), 32'(e.vm));
    endtask

    task automatic step_cycle(input bit hs, input bit vs, input logic [29:0] rgb);
        exp_t e;
        @(negedge px_clk);
        if (q.size() == 2) begin
            e = q.pop_front();
            check_outputs(e);
        end
        if (px_valid)    n_valid++;
        if (frame_start) n_fs++;
        if (timing_err)  n_err++;
        drive(hs, vs, rgb);
        q.push_back(model_step(hs, vs, rgb));
    endtask

    task automatic apply_reset();
        @(negedge px_clk);
        rst = 1'b1;
        drive(T_POL, T_POL, '0);
        #1;
        check_eq("rst_px_valid",    32'(px_valid),     0);
        check_eq("rst_frame_start", 32'(frame_start),  0);
        check_eq("rst_px_h",        32'(px_h),         0);
        check_eq("rst_px_v",        32'(px_v),         0);
        check_eq("rst_px_data",     32'(px_data),      0);
        check_eq("rst_locked",      32'(locked),       0);
        check_eq("rst_timing_err",  32'(timing_err),   0);
        check_eq("rst_h_total",     32'(h_total_meas), 0);
        check_eq("rst_v_total",     32'(v_total_meas), 0);
        q.delete();
        model_reset();
        @(negedge px_clk);
        rst = 1'b0;
        q.push_back(model_step(T_POL, T_POL, '0));
        q.push_back(model_step(T_POL, T_POL, '0));
    endtask

    task automatic gen_frame(input int stretch_line, input int rst_line, input int rst_pos);
        int len;
        for (int l = 0; l < T_VT; l++) begin
            len = (l == stretch_line) ? T_HT + 1 : T_HT;
            for (int p = 0; p < len; p++) begin
                if (l == rst_line && p == rst_pos) apply_reset();
                step_cycle((p < T_H_PW) ? !T_POL : T_POL,
                           (l < T_V_PW) ? !T_POL : T_POL,
                           30'($urandom()));
            end
        end
    endtask

    initial begin
        drive(T_POL, T_POL, '0);
        model_reset();
        apply_reset();

        repeat (2) gen_frame(-1, -1, -1);
        check_eq("unlocked_before_3rd_vsync", 32'(locked), 0);
        gen_frame(-1, -1, -1);
        check_eq("locked_after_3rd_vsync", 32'(locked), 1);
        check_eq("h_total_nominal", 32'(h_total_meas), T_HT);
        check_eq("v_total_nominal", 32'(v_total_meas), T_VT);

        n_valid = 0;
        n_fs    = 0;
        gen_frame(-1, -1, -1);
        check_eq("valid_per_frame", n_valid, T_H_DATA * T_V_DATA);
        check_eq("frame_start_per_frame", n_fs, 1);

        n_err = 0;
        gen_frame($urandom_range(1, T_VT - 2), -1, -1);
        check_eq("stretch_err_pulses", n_err, 1);
        check_eq("stretch_unlocked", 32'(locked), 0);
        repeat (2) gen_frame(-1, -1, -1);
        check_eq("stretch_no_early_relock", 32'(locked), 0);
        gen_frame(-1, -1, -1);
        check_eq("stretch_relocked", 32'(locked), 1);

        n_err   = 0;
        n_valid = 0;
        repeat (5000) step_cycle(T_POL, T_POL, 30'($urandom()));
        check_eq("idle_err_pulses", n_err, 1);
        check_eq("idle_no_valid", n_valid, 0);
        check_eq("idle_unlocked", 32'(locked), 0);
        repeat (2) gen_frame(-1, -1, -1);
        check_eq("idle_no_early_relock", 32'(locked), 0);
        gen_frame(-1, -1, -1);
        check_eq("idle_relocked", 32'(locked), 1);

        gen_frame(-1, $urandom_range(VS0, VS0 + T_V_DATA - 1),
                  $urandom_range(HS0 + 1, HS0 + T_H_DATA - 2));
        check_eq("rst_midline_unlocked", 32'(locked), 0);
        repeat (2) gen_frame(-1, -1, -1);
        check_eq("rst_no_early_relock", 32'(locked), 0);
        gen_frame(-1, -1, -1);
        check_eq("rst_relocked", 32'(locked), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
